// File: rtl/ramb4_s2_reader.sv
// rtl/ramb4_s2_reader.sv - burst reader for a 2048x2 synchronous-read block RAM
// Streams words out through a 2-entry skid buffer so backpressure never drops a read in flight.
module ramb4_s2_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W:0]   LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_RST,
    input  logic [DATA_W-1:0] RAM_DO,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [1:0]          occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;

    logic                pop;
    logic                issue;
    logic [2:0]          level;
    logic [1:0]          occ_after_pop;

    always_comb begin
        pop   = (occ_q != 2'd0) && M_READY;
        // Slots that will be committed after this edge if nothing new is issued.
        level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == S_RUN) && (remaining_q != '0) && (level < 3'd2);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        occ_d         = occ_q;
        inflight_d    = issue;
        done_d        = 1'b0;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        occ_after_pop = occ_q;

        if (pop) begin
            buf0_d        = buf1_q;
            occ_after_pop = occ_q - 2'd1;
        end
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                buf0_d = RAM_DO;
            end else begin
                buf1_d = RAM_DO;
            end
            occ_d = occ_after_pop + 2'd1;
        end else begin
            occ_d = occ_after_pop;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = BASE;
                        remaining_d = (LEN > DEPTH) ? DEPTH : LEN;
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (occ_d == 2'd0) && !issue) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert ({1'b0, occ_q} + {2'b00, inflight_q} <= 3'd2);
        end
    end

    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign RAM_ADDR = addr_q;
    assign RAM_EN   = issue;
    assign RAM_WE   = 1'b0;
    assign RAM_RST  = 1'b0;
    assign M_DATA   = buf0_q;
    assign M_VALID  = (occ_q != 2'd0);

endmodule
